// File: rtl/ai_core_pkg.sv
// Shared types and defaults for the ai_core dot-product datapath.
// Holds the accumulator FSM states and a signed-overflow helper.
package ai_core_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int IN_SIZE_DEFAULT   = 16;
  localparam int ACC_SIZE_DEFAULT  = 32;
  localparam int MAX_BEATS_DEFAULT = 256;

  // Two's-complement add overflowed: like-signed operands gave the other sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cpa_accumulator_if.sv
// Beat input and result output handshakes of the CPA accumulator.
// Signal names keep the block's port names so the bus reads like the port list.
interface cpa_accumulator_if #(
  parameter int IN_SIZE  = 16,
  parameter int ACC_SIZE = 32,
  parameter int CNT_W    = 9
) ();

  logic                clear_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [IN_SIZE-1:0]  sum_i;
  logic [IN_SIZE-1:0]  carry_i;
  logic                last_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [ACC_SIZE-1:0] acc_o;
  logic [CNT_W-1:0]    beats_o;
  logic                overflow_o;

  modport slave (
    input  clear_i, in_valid_i, sum_i, carry_i, last_i, out_ready_i,
    output in_ready_o, out_valid_o, acc_o, beats_o, overflow_o
  );

  modport master (
    output clear_i, in_valid_i, sum_i, carry_i, last_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc_o, beats_o, overflow_o
  );

endinterface

// File: rtl/cpa_n_bit.sv
// Combinational carry-propagate adder, (a + b) mod 2^WIDTH.
// The carry out of the top bit is deliberately dropped.
module cpa_n_bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/cpa_accumulator.sv
// Resolves redundant (sum, carry) beats and accumulates them per vector,
// returning the signed total, beat count and sticky overflow on a handshake.
module cpa_accumulator
  import ai_core_pkg::*;
#(
  parameter int IN_SIZE   = IN_SIZE_DEFAULT,
  parameter int ACC_SIZE  = ACC_SIZE_DEFAULT,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  cpa_accumulator_if.slave        bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  acc_state_e          state_reg;
  logic                s1_valid_reg;
  logic                s1_last_reg;
  logic [ACC_SIZE-1:0] s1_val_reg;
  logic [ACC_SIZE-1:0] acc_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                sticky_reg;
  logic                out_valid_reg;
  logic [ACC_SIZE-1:0] acc_out_reg;
  logic [CNT_W-1:0]    beats_out_reg;
  logic                overflow_out_reg;

  logic [IN_SIZE-1:0]  beat_raw;
  logic [ACC_SIZE-1:0] beat_ext;
  logic [ACC_SIZE-1:0] add_b;
  logic [ACC_SIZE-1:0] acc_sum;
  logic                in_ready;
  logic                accept;
  logic                fold;
  logic                add_ovf;

  cpa_n_bit #(.WIDTH(IN_SIZE)) u_beat_cpa (
    .a   (bus.sum_i),
    .b   (bus.carry_i),
    .sum (beat_raw)
  );

  assign beat_ext = {{(ACC_SIZE - IN_SIZE){beat_raw[IN_SIZE-1]}}, beat_raw};

  assign in_ready = (state_reg == ACC);
  assign accept   = bus.in_valid_i & in_ready;

  // In DRAIN the stage-1 register holds the closing beat, so only fold it then.
  assign fold  = s1_valid_reg & (s1_last_reg | (state_reg == ACC));
  assign add_b = fold ? s1_val_reg : '0;

  cpa_n_bit #(.WIDTH(ACC_SIZE)) u_acc_cpa (
    .a   (acc_reg),
    .b   (add_b),
    .sum (acc_sum)
  );

  assign add_ovf = fold & signed_ovf(acc_reg[ACC_SIZE-1], add_b[ACC_SIZE-1], acc_sum[ACC_SIZE-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= ACC;
      s1_valid_reg     <= 1'b0;
      s1_last_reg      <= 1'b0;
      s1_val_reg       <= '0;
      acc_reg          <= '0;
      count_reg        <= '0;
      sticky_reg       <= 1'b0;
      out_valid_reg    <= 1'b0;
      acc_out_reg      <= '0;
      beats_out_reg    <= '0;
      overflow_out_reg <= 1'b0;
    end else if (bus.clear_i) begin
      state_reg     <= ACC;
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      acc_reg       <= '0;
      count_reg     <= '0;
      sticky_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_val_reg   <= beat_ext;
        s1_last_reg  <= bus.last_i;
      end else begin
        s1_valid_reg <= 1'b0;
        s1_last_reg  <= 1'b0;
      end

      unique case (state_reg)
        ACC: begin
          if (fold) begin
            acc_reg    <= acc_sum;
            sticky_reg <= sticky_reg | add_ovf;
          end
          if (accept) begin
            if (count_reg < MAX_CNT) begin
              count_reg <= count_reg + CNT_W'(1);
            end
            if (bus.last_i) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          acc_out_reg      <= acc_sum;
          beats_out_reg    <= count_reg;
          overflow_out_reg <= sticky_reg | add_ovf;
          out_valid_reg    <= 1'b1;
          acc_reg          <= '0;
          count_reg        <= '0;
          sticky_reg       <= 1'b0;
          state_reg        <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready_i) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ACC;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_reg;
  assign bus.acc_o       = acc_out_reg;
  assign bus.beats_o     = beats_out_reg;
  assign bus.overflow_o  = overflow_out_reg;

endmodule
